demultiplexor_tdm_1a4: RTL
==========================

DEMULTIPLEXOR_TDM_1A4 -- requirements
Module: demultiplexor_tdm_1a4

Interface
REQ-001 Parameter: ANCHO, default 8, width in bits of each time slot word.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: din  input  ANCHO  serial time-division word stream from the 4-to-1 multiplexer side.
REQ-005 Port: din_valid  input  1  din carries a word this cycle.
REQ-006 Port: sync  input  1  qualified by din_valid; marks the current word as slot 0 of a frame.
REQ-007 Port: A  output  4*ANCHO  demultiplexed frame; slot i on A[i*ANCHO +: ANCHO].
REQ-008 Port: trama_valida  output  1  one-cycle pulse; A holds a new complete frame.
REQ-009 Port: sel  output  2  index of the slot the next accepted word will fill.
REQ-010 Port: error_sync  output  1  one-cycle pulse on framing violation.
REQ-011 Port: alineado  output  1  high while the FSM is in state ALINEADO.
REQ-012 Port: cont_tramas  output  8  count of completed frames.

Function
REQ-013 The block SHALL implement a two-state FSM: BUSCA (hunting for frame start) and ALINEADO (locked).
REQ-014 In BUSCA, words with din_valid=1 and sync=0 SHALL be discarded, with no output change other than error_sync staying 0.
REQ-015 In BUSCA, a word with din_valid=1 and sync=1 SHALL be stored as slot 0, set sel to 1, and move the FSM to ALINEADO.
REQ-016 In ALINEADO, each word with din_valid=1 SHALL be stored in a shadow register at index sel, and sel SHALL increment modulo 4.
REQ-017 Cycles with din_valid=0 SHALL leave sel, the FSM state and the shadow registers unchanged; gaps of any length are legal.
REQ-018 When the slot 3 word is accepted at edge k, all four slots of A SHALL update together (slots 0-2 from shadow, slot 3 from din) at edge k.
REQ-019 At edge k trama_valida SHALL go high for exactly one cycle, sel SHALL wrap to 0, and cont_tramas SHALL increment, wrapping 255 to 0.
REQ-020 A SHALL hold its value between frames; partial frames SHALL never be visible on A.
REQ-021 In ALINEADO, a word with sync=1 at sel!=0 SHALL pulse error_sync for one cycle and discard the partial frame.
REQ-022 That sync word (REQ-021) SHALL be stored as slot 0, with sel set to 1 and the FSM remaining in ALINEADO (realign).
REQ-023 In ALINEADO, a word with sync=0 at sel=0 SHALL pulse error_sync, discard the word, and return the FSM to BUSCA.
REQ-024 The word at sel=0 in REQ-023 SHALL leave sel at 0.
REQ-025 A valid sync word at sel=0 in ALINEADO SHALL be accepted normally with no error.
REQ-026 trama_valida and error_sync SHALL never be high in the same cycle.
REQ-027 sel, alineado, A, trama_valida and error_sync SHALL be driven directly from registers.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL set A=0, shadow=0, sel=0, cont_tramas=0, trama_valida=0, error_sync=0 and the FSM to BUSCA (alineado=0).
REQ-029 rst SHALL take priority over din_valid in the same cycle; a frame in progress SHALL be discarded without a trama_valida pulse.
REQ-030 The first word accepted after rst deasserts SHALL be processed under BUSCA rules.

Verification
REQ-031 The bench SHALL cover nominal operation (ANCHO=8): after reset, send 8'h01(sync),8'h00,8'h01,8'h00 on consecutive cycles.
  Required response: A=32'h00010001 one cycle after the last word; trama_valida pulses once; cont_tramas=1; sel=0.
REQ-032 The bench SHALL cover gaps: the same frame with din_valid=0 for 3 cycles between each word.
  Required response: identical A; a single trama_valida pulse; sel holds during the gaps.
REQ-033 The bench SHALL cover hunting: in BUSCA, send 8'hAA,8'hBB with sync=0, then 8'h11(sync),8'h22,8'h33,8'h44.
  Required response: no error_sync; A=32'h44332211.
REQ-034 The bench SHALL cover early sync: after 8'h11(sync),8'h22, send 8'h55(sync),8'h66,8'h77,8'h88.
  Required response: error_sync pulses on the 8'h55 word; A=32'h88776655; the previous A is unchanged until then.
REQ-035 The bench SHALL cover missing sync: after one complete frame, send 8'h99 with sync=0.
  Required response: error_sync pulses; alineado=0; A and cont_tramas unchanged.
REQ-036 The bench SHALL cover reset mid-frame and counter wrap:
  Reset mid-frame: assert rst after slot 2 -> no trama_valida, all outputs 0.
  Counter wrap: 256 complete frames -> cont_tramas=0.

Source files
------------

// File: rtl/demultiplexor_tdm_1a4.sv
`default_nettype none
// ============================================================================
// Module   : demultiplexor_tdm_1a4
// Purpose  : 1-to-4 TDM demultiplexer with sync-word framing and realignment.
// Revision : 1.0
// ============================================================================
module demultiplexor_tdm_1a4 #(
    parameter int ANCHO = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ANCHO-1:0]   din,
    input  logic               din_valid,
    input  logic               sync,
    output logic [4*ANCHO-1:0] A,
    output logic               trama_valida,
    output logic [1:0]         sel,
    output logic               error_sync,
    output logic               alineado,
    output logic [7:0]         cont_tramas
);

    typedef enum logic [0:0] {
        BUSCA    = 1'b0,
        ALINEADO = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       sel_next;
    logic             w_store;
    logic             w_frame;
    logic             w_err;
    logic [1:0]       w_slot;
    logic [ANCHO-1:0] r_shadow [3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BUSCA;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        w_store    = 1'b0;
        w_frame    = 1'b0;
        w_err      = 1'b0;
        case (state)
            BUSCA: begin
                if (din_valid && sync) begin
                    w_store    = 1'b1;
                    sel_next   = 2'd1;
                    state_next = ALINEADO;
                end
            end
            ALINEADO: begin
                if (din_valid) begin
                    if (sync && (sel != 2'd0)) begin
                        // Early sync: drop the partial frame and restart at slot 0.
                        w_err    = 1'b1;
                        w_store  = 1'b1;
                        sel_next = 2'd1;
                    end else if (!sync && (sel == 2'd0)) begin
                        w_err      = 1'b1;
                        state_next = BUSCA;
                    end else if (sel == 2'd3) begin
                        w_frame  = 1'b1;
                        sel_next = 2'd0;
                    end else begin
                        w_store  = 1'b1;
                        sel_next = sel + 2'd1;
                    end
                end
            end
            default: begin
                state_next = BUSCA;
            end
        endcase
    end

    // A sync word always lands in slot 0; otherwise the word goes where sel points.
    assign w_slot = sync ? 2'd0 : sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            A            <= '0;
            sel          <= 2'd0;
            cont_tramas  <= 8'd0;
            trama_valida <= 1'b0;
            error_sync   <= 1'b0;
            alineado     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            sel          <= sel_next;
            trama_valida <= w_frame;
            error_sync   <= w_err;
            alineado     <= (state_next == ALINEADO);
            for (int i = 0; i < 3; i++) begin
                if (w_store && (w_slot == i[1:0])) begin
                    r_shadow[i] <= din;
                end
            end
            if (w_frame) begin
                A           <= {din, r_shadow[2], r_shadow[1], r_shadow[0]};
                cont_tramas <= cont_tramas + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
